rr_arb_mux: RTL

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_if.sv | 36 +++
 rtl/rr_arb_mux.sv | 110 +++++++++++
 2 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N requesting channels and one registered output port.
// "slave" is the arbiter side; "master" is the environment driving requests and consuming output.
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
// Round-robin or fixed lowest-index priority; full throughput under continuous out_ready.
module rr_arb_mux #(
    parameter int WIDTH      = 32,
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0
) (
    input logic         clk,
    input logic         rst,
    rr_arb_mux_if.slave bus
);
    localparam int              SELW     = (N > 2) ? $clog2(N) : 1;
    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

    logic [SELW-1:0]  last_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;

    logic [SELW-1:0]  win_s;
    logic [WIDTH-1:0] win_word_s;
    logic [N-1:0]     grant_s;
    logic             load_ok_s;
    logic             any_req_s;
    logic             grant_en_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Search starts just after the last winner and wraps; indices stay below N.
    function automatic logic [SELW-1:0] pick_rr(input logic [N-1:0] req,
                                                input logic [SELW-1:0] ptr);
        logic [SELW-1:0] win;
        logic            found;
        int              idx;
        win   = {SELW{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                win   = SELW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    function automatic logic [SELW-1:0] pick_fixed(input logic [N-1:0] req);
        logic [SELW-1:0] win;
        win = {SELW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                win = SELW'(k);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Winner selection, grant vector and transfer qualifiers.
    always_comb begin
        any_req_s  = |bus.in_valid;
        load_ok_s  = ~out_valid_r | bus.out_ready;
        grant_en_s = ~rst & load_ok_s & any_req_s;
        if (FIXED_PRIO != 0) begin
            win_s = pick_fixed(bus.in_valid);
        end else begin
            win_s = pick_rr(bus.in_valid, last_r);
        end
        grant_s    = {N{1'b0}};
        win_word_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (win_s == SELW'(i)) begin
                grant_s[i] = grant_en_s;
                win_word_s = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_s[i] = 1'b0;
            end
        end
        in_xfer_s  = |(bus.in_valid & grant_s);
        out_xfer_s = out_valid_r & bus.out_ready;
    end

    // Output register and arbitration pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SELW{1'b0}};
            last_r      <= LAST_RST;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= win_word_s;
            out_sel_r   <= win_s;
            last_r      <= win_s;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = grant_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

endmodule
